// File: rtl/rd_fwft_ctrl.sv
// rd_fwft_ctrl: async FIFO read-side controller with Gray pointer compare, fill level and FWFT output stage
module rd_fwft_ctrl #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32,
    parameter int AE_THRESH  = 2
) (
    input  logic                  i_rclk,
    input  logic                  i_rrst_n,
    input  logic [ADDR_WIDTH:0]   i_rq2_wptr,
    input  logic [DATA_WIDTH-1:0] i_rdata_mem,
    output logic [ADDR_WIDTH:0]   o_rptr,
    output logic [ADDR_WIDTH-1:0] o_raddr,
    output logic                  o_rempty,
    output logic [ADDR_WIDTH:0]   o_rlevel,
    output logic                  o_almost_empty,
    output logic [DATA_WIDTH-1:0] o_dout,
    output logic                  o_dout_valid,
    input  logic                  i_dout_ready,
    output logic                  o_ptr_err
);
    localparam int PW = ADDR_WIDTH + 1;
    localparam logic [PW-1:0] DEPTH_P = PW'(2 ** ADDR_WIDTH);
    localparam logic [PW-1:0] AE_P    = PW'(AE_THRESH);

    typedef enum logic {HOLD_EMPTY, HOLD_FULL} state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [PW-1:0]       r_rbin;
    logic [PW-1:0]       r_rptr;
    logic                r_rempty;
    logic [PW-1:0]       r_rlevel;
    logic                r_almost_empty;
    logic [DATA_WIDTH-1:0] r_dout;
    logic                r_ptr_err;
    logic                w_fetch;
    logic [PW-1:0]       w_rbin_next;
    logic [PW-1:0]       w_rgray_next;
    logic [PW-1:0]       w_wbin;
    logic [PW-1:0]       w_diff;
    logic                w_over;

    assign o_dout_valid   = (r_state == HOLD_FULL);
    assign w_fetch        = ~r_rempty & (~o_dout_valid | i_dout_ready);
    assign w_rbin_next    = r_rbin + PW'(w_fetch);
    assign w_rgray_next   = (w_rbin_next >> 1) ^ w_rbin_next;
    assign w_diff         = w_wbin - w_rbin_next;
    assign w_over         = w_diff > DEPTH_P;
    assign o_rptr         = r_rptr;
    assign o_raddr        = r_rbin[ADDR_WIDTH-1:0];
    assign o_rempty       = r_rempty;
    assign o_rlevel       = r_rlevel;
    assign o_almost_empty = r_almost_empty;
    assign o_dout         = r_dout;
    assign o_ptr_err      = r_ptr_err;

    // Gray-to-binary of the synchronised write pointer: each bit is the XOR of itself and all higher bits
    always_comb begin
        w_wbin = '0;
        for (int i = 0; i < PW; i++) w_wbin[i] = ^(i_rq2_wptr >> i);
    end

    // Output slot: a fetch always (re)fills it; otherwise an accepted word empties it
    always_comb begin
        w_state_next = w_fetch ? HOLD_FULL : (i_dout_ready ? HOLD_EMPTY : r_state);
    end

    // Pointers, flags, level and output register
    always_ff @(posedge i_rclk or negedge i_rrst_n) begin
        if (!i_rrst_n) begin
            r_state        <= HOLD_EMPTY;
            r_rbin         <= '0;
            r_rptr         <= '0;
            r_rempty       <= 1'b1;
            r_rlevel       <= '0;
            r_almost_empty <= 1'b1;
            r_dout         <= '0;
            r_ptr_err      <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_rbin         <= w_rbin_next;
            r_rptr         <= w_rgray_next;
            r_rempty       <= (w_rgray_next == i_rq2_wptr);
            r_rlevel       <= w_over ? DEPTH_P : w_diff;
            r_almost_empty <= (w_diff <= AE_P);
            r_ptr_err      <= r_ptr_err | w_over;
            if (w_fetch) r_dout <= i_rdata_mem;
        end
    end
endmodule

// File: tb/tb_rd_fwft_ctrl.sv
// tb_rd_fwft_ctrl: randomized self-checking bench for rd_fwft_ctrl against a word-count reference model
module tb_rd_fwft_ctrl;
    logic        clk = 1'b0;
    logic        rrst_n = 1'b0;
    logic [4:0]  rq2_wptr = '0;
    logic [31:0] rdata_mem;
    logic [4:0]  rptr;
    logic [3:0]  raddr;
    logic        rempty;
    logic [4:0]  rlevel;
    logic        almost_empty;
    logic [31:0] dout;
    logic        dout_valid;
    logic        dout_ready = 1'b0;
    logic        ptr_err;

    logic [31:0] mem [16];
    int checks = 0;
    int errors = 0;

    // Reference model: counts of words written/fetched plus the output slot contents
    int          n_wr, n_rd, m_level;
    bit          m_empty, m_valid, m_ae;
    logic [31:0] m_dout;
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;
    assign rdata_mem = mem[raddr];

    rd_fwft_ctrl dut (
        .i_rclk(clk), .i_rrst_n(rrst_n), .i_rq2_wptr(rq2_wptr), .i_rdata_mem(rdata_mem),
        .o_rptr(rptr), .o_raddr(raddr), .o_rempty(rempty), .o_rlevel(rlevel),
        .o_almost_empty(almost_empty), .o_dout(dout), .o_dout_valid(dout_valid),
        .i_dout_ready(dout_ready), .o_ptr_err(ptr_err)
    );

    function automatic logic [4:0] gray(input int b);
        logic [4:0] x;
        x = 5'(b);
        return x ^ (x >> 1);
    endfunction

    task automatic model_reset();
        n_wr = 0; n_rd = 0; m_level = 0;
        m_empty = 1; m_valid = 0; m_ae = 1; m_dout = '0;
        exp_q.delete();
    endtask

    task automatic write_word(input logic [31:0] d);
        mem[n_wr % 16] = d;
        exp_q.push_back(d);
        n_wr++;
    endtask

    task automatic check_all(input string tag);
        checks++; if (rptr !== gray(n_rd)) begin errors++; $display("FAIL %s rptr got %h exp %h", tag, rptr, gray(n_rd)); end
        checks++; if (raddr !== 4'(n_rd)) begin errors++; $display("FAIL %s raddr got %0d exp %0d", tag, raddr, n_rd % 16); end
        checks++; if (rempty !== m_empty) begin errors++; $display("FAIL %s rempty got %b exp %b", tag, rempty, m_empty); end
        checks++; if (rlevel !== 5'(m_level)) begin errors++; $display("FAIL %s rlevel got %0d exp %0d", tag, rlevel, m_level); end
        checks++; if (almost_empty !== m_ae) begin errors++; $display("FAIL %s almost_empty got %b exp %b", tag, almost_empty, m_ae); end
        checks++; if (dout_valid !== m_valid) begin errors++; $display("FAIL %s dout_valid got %b exp %b", tag, dout_valid, m_valid); end
        if (m_valid) begin
            checks++; if (dout !== m_dout) begin errors++; $display("FAIL %s dout got %h exp %h", tag, dout, m_dout); end
        end
        checks++; if (ptr_err !== 1'b0) begin errors++; $display("FAIL %s ptr_err got %b exp 0", tag, ptr_err); end
    endtask

    // One rclk cycle: drive inputs, score any delivery, advance the model, check every output
    task automatic cycle(input bit rdy, input string tag);
        bit          fetch;
        int          wn;
        logic [31:0] d, e;
        dout_ready = rdy;
        rq2_wptr = gray(n_wr);
        wn = n_wr;
        fetch = !m_empty && (!m_valid || rdy);
        d = mem[n_rd % 16];
        if (dout_valid && rdy) begin
            checks++;
            if (exp_q.size() == 0) begin errors++; $display("FAIL %s delivery got %h exp none", tag, dout); end
            else begin
                e = exp_q.pop_front();
                if (dout !== e) begin errors++; $display("FAIL %s delivery got %h exp %h", tag, dout, e); end
            end
        end
        @(posedge clk); #1;
        if (fetch) begin m_dout = d; m_valid = 1; n_rd++; end
        else if (rdy) m_valid = 0;
        m_level = wn - n_rd;
        m_empty = (m_level == 0);
        m_ae = (m_level <= 2);
        check_all(tag);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rrst_n = 1'b0; dout_ready = 1'b0; rq2_wptr = '0;
        model_reset();
        #2;
        @(negedge clk); rrst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        do_reset();
        check_all("reset");
        checks++; if (rptr !== 5'h00 || rempty !== 1'b1 || rlevel !== 5'd0) begin
            errors++; $display("FAIL reset_const rptr=%h rempty=%b rlevel=%0d exp 00 1 0", rptr, rempty, rlevel);
        end
    endtask

    task automatic test_single();
        do_reset();
        write_word(32'hA5A5_0001);
        cycle(0, "single_e1");
        checks++; if (rempty !== 1'b0 || rlevel !== 5'd1) begin
            errors++; $display("FAIL single_e1 rempty=%b rlevel=%0d exp 0 1", rempty, rlevel);
        end
        cycle(0, "single_e2");
        checks++; if (dout !== 32'hA5A5_0001 || dout_valid !== 1'b1 || rptr !== 5'b00001 || rempty !== 1'b1) begin
            errors++; $display("FAIL single_e2 dout=%h v=%b rptr=%b rempty=%b exp a5a50001 1 00001 1", dout, dout_valid, rptr, rempty);
        end
        repeat (3) cycle(0, "single_hold");
        cycle(1, "single_take");
        checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL single_take dout_valid got %b exp 0", dout_valid); end
    endtask

    task automatic test_full_drain();
        do_reset();
        for (int i = 0; i < 16; i++) write_word(32'hD000_0000 | 32'(i));
        repeat (20) cycle(1, "drain");
        checks++; if (rptr !== 5'b11000 || rempty !== 1'b1 || exp_q.size() != 0) begin
            errors++; $display("FAIL drain_end rptr=%b rempty=%b left=%0d exp 11000 1 0", rptr, rempty, exp_q.size());
        end
    endtask

    task automatic test_backpressure();
        bit pat [4] = '{1, 0, 0, 1};
        for (int i = 0; i < 4; i++) write_word($urandom);
        for (int i = 0; i < 16; i++) cycle(pat[i % 4], "bp");
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL bp_left got %0d exp 0", exp_q.size()); end
    endtask

    task automatic test_wrap_random();
        int start;
        start = n_rd;
        for (int c = 0; c < 400 && n_rd < start + 40; c++) begin
            for (int k = $urandom_range(0, 2); k > 0 && (n_wr - n_rd) < 16; k--) write_word($urandom);
            cycle($urandom_range(0, 3) != 0, "wrap");
        end
        repeat (40) cycle(1, "wrap_flush");
        checks++; if (n_rd < start + 40 || exp_q.size() != 0) begin
            errors++; $display("FAIL wrap_progress read %0d left %0d exp >=40 0", n_rd - start, exp_q.size());
        end
    endtask

    task automatic test_ptr_err();
        do_reset();
        rq2_wptr = 5'b11110;
        @(posedge clk); #1;
        checks++; if (ptr_err !== 1'b1 || rlevel !== 5'd16) begin
            errors++; $display("FAIL ptr_err_set ptr_err=%b rlevel=%0d exp 1 16", ptr_err, rlevel);
        end
        rq2_wptr = 5'b00000;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (ptr_err !== 1'b1) begin errors++; $display("FAIL ptr_err_sticky got %b exp 1", ptr_err); end
        #2 rrst_n = 1'b0;
        #1;
        checks++; if (ptr_err !== 1'b0 || dout_valid !== 1'b0 || rptr !== 5'd0 || rlevel !== 5'd0 || rempty !== 1'b1 || almost_empty !== 1'b1 || dout !== 32'd0) begin
            errors++; $display("FAIL mid_reset err=%b v=%b rptr=%h lvl=%0d e=%b ae=%b dout=%h exp 0 0 00 0 1 1 0",
                               ptr_err, dout_valid, rptr, rlevel, rempty, almost_empty, dout);
        end
        model_reset();
        @(negedge clk); rrst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = '0;
        model_reset();
        test_reset();
        test_single();
        test_full_drain();
        test_backpressure();
        test_wrap_random();
        test_ptr_err();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
